// File: rtl/piarb_class_sch.sv
// Class-based dequeue scheduler: per-class event FIFOs fed by enqueue-to-empty
// and re-arm events, strict-priority or WRR selection, bounded in-flight requests.
module piarb_class_sch #(
   parameter int unsigned QUEUE_ID_NBITS  = 5,
   parameter int unsigned NUM_CLASS       = 4,
   parameter int unsigned EVT_DEPTH_NBITS = 5,
   parameter int unsigned WEIGHT_NBITS    = 4,
   parameter int unsigned INFLIGHT_DEPTH  = 4,
   localparam int unsigned CLASS_NBITS    = (NUM_CLASS > 1) ? $clog2(NUM_CLASS) : 1
) (
   input  logic                              clk,
   input  logic                              rstn,
   input  logic                              enq_ack,
   input  logic                              enq_to_empty,
   input  logic [QUEUE_ID_NBITS-1:0]         enq_ack_qid,
   input  logic [CLASS_NBITS-1:0]            enq_ack_class,
   input  logic                              deq_depth_ack,
   input  logic                              deq_depth_from_emptyp2,
   input  logic                              mode,
   input  logic [NUM_CLASS*WEIGHT_NBITS-1:0] weight,
   input  logic                              deq_ready,
   output logic                              deq_req,
   output logic [QUEUE_ID_NBITS-1:0]         deq_qid,
   output logic [CLASS_NBITS-1:0]            deq_class,
   output logic [NUM_CLASS-1:0]              evt_overflow,
   output logic                              inflight_err
);
   localparam int unsigned EW        = QUEUE_ID_NBITS + CLASS_NBITS;
   localparam int unsigned EVT_DEPTH = 1 << EVT_DEPTH_NBITS;
   localparam int unsigned EC        = EVT_DEPTH_NBITS + 1;
   localparam int unsigned STG_DEPTH = 4;
   localparam int unsigned IF_PW     = (INFLIGHT_DEPTH > 1) ? $clog2(INFLIGHT_DEPTH) : 1;
   localparam int unsigned IF_CW     = $clog2(INFLIGHT_DEPTH + 1);

   logic [EW-1:0]              stg_mem [STG_DEPTH];
   logic [1:0]                 stg_wr, stg_rd;
   logic [2:0]                 stg_cnt;
   logic [EW-1:0]              if_mem [INFLIGHT_DEPTH];
   logic [IF_PW-1:0]           if_wr, if_rd;
   logic [IF_CW-1:0]           if_cnt;
   logic [QUEUE_ID_NBITS-1:0]  evt_mem [NUM_CLASS][EVT_DEPTH];
   logic [EVT_DEPTH_NBITS-1:0] evt_wr [NUM_CLASS];
   logic [EVT_DEPTH_NBITS-1:0] evt_rd [NUM_CLASS];
   logic [EC-1:0]              evt_cnt [NUM_CLASS];
   logic [CLASS_NBITS-1:0]     wrr_ptr;
   logic [WEIGHT_NBITS-1:0]    wrr_credit;

   logic                       enq_evt, if_pop, rearm, stg_pop, stg_push;
   logic                       evt_push, evt_accept, sel_vld, found;
   logic [EW-1:0]              push_ent;
   logic [CLASS_NBITS-1:0]     push_cls, sel_cls, ptr_nxt;
   logic [QUEUE_ID_NBITS-1:0]  push_qid, sel_qid;
   logic [NUM_CLASS-1:0]       nonempty, evt_pop, evt_wr_en, ovf_set;
   logic [WEIGHT_NBITS-1:0]    base, credit_nxt;
   int unsigned                idx;

   function automatic logic [WEIGHT_NBITS-1:0] eff_weight(input logic [CLASS_NBITS-1:0] c);
      logic [WEIGHT_NBITS-1:0] w;
      w = weight[32'(c)*WEIGHT_NBITS +: WEIGHT_NBITS];
      return (w == '0) ? WEIGHT_NBITS'(1) : w;
   endfunction

   function automatic logic [IF_PW-1:0] if_inc(input logic [IF_PW-1:0] p);
      return (p == IF_PW'(INFLIGHT_DEPTH - 1)) ? '0 : p + IF_PW'(1);
   endfunction

   // Event sourcing: a re-arm of the in-flight head beats the staging head
   always_comb begin
      enq_evt  = enq_ack & enq_to_empty;
      if_pop   = deq_depth_ack & (if_cnt != '0);
      rearm    = if_pop & deq_depth_from_emptyp2;
      stg_pop  = ~rearm & (stg_cnt != '0);
      stg_push = enq_evt & ((stg_cnt != 3'(STG_DEPTH)) | stg_pop);
      evt_push = rearm | stg_pop;
      push_ent = rearm ? if_mem[if_rd] : stg_mem[stg_rd];
      push_cls = push_ent[CLASS_NBITS-1:0];
      push_qid = push_ent[EW-1:CLASS_NBITS];
      for (int c = 0; c < int'(NUM_CLASS); c++) nonempty[c] = (evt_cnt[c] != '0);
   end

   // Selection; a slot freed by this cycle's ack is usable immediately
   always_comb begin
      sel_cls    = '0;
      found      = 1'b0;
      base       = WEIGHT_NBITS'(1);
      ptr_nxt    = wrr_ptr;
      credit_nxt = wrr_credit;
      idx        = 0;
      sel_vld    = deq_ready & ((if_cnt < IF_CW'(INFLIGHT_DEPTH)) | if_pop) & (|nonempty);
      if (!mode) begin
         for (int c = int'(NUM_CLASS) - 1; c >= 0; c--)
            if (nonempty[c]) sel_cls = CLASS_NBITS'(c);
      end else begin
         // credit 0 at the pointer means the pointer class is being entered fresh
         if (nonempty[wrr_ptr]) begin
            sel_cls = wrr_ptr;
            base    = (wrr_credit == '0) ? eff_weight(wrr_ptr) : wrr_credit;
         end else begin
            for (int unsigned i = 1; i <= NUM_CLASS; i++) begin
               idx = (32'(wrr_ptr) + i) % NUM_CLASS;
               if (!found && nonempty[idx]) begin
                  found   = 1'b1;
                  sel_cls = CLASS_NBITS'(idx);
               end
            end
            base = eff_weight(sel_cls);
         end
         if (sel_vld) begin
            credit_nxt = base - WEIGHT_NBITS'(1);
            ptr_nxt    = (credit_nxt == '0) ? CLASS_NBITS'((32'(sel_cls) + 1) % NUM_CLASS) : sel_cls;
         end
      end
      sel_qid = evt_mem[sel_cls][evt_rd[sel_cls]];
      for (int c = 0; c < int'(NUM_CLASS); c++) evt_pop[c] = sel_vld & (sel_cls == CLASS_NBITS'(c));
   end

   // Event FIFO push acceptance and overflow flags
   always_comb begin
      evt_accept = evt_push & ((evt_cnt[push_cls] != EC'(EVT_DEPTH)) | evt_pop[push_cls]);
      ovf_set    = '0;
      for (int c = 0; c < int'(NUM_CLASS); c++) evt_wr_en[c] = evt_accept & (push_cls == CLASS_NBITS'(c));
      if (evt_push & ~evt_accept) ovf_set[push_cls] = 1'b1;
      if (enq_evt & ~stg_push) ovf_set[enq_ack_class] = 1'b1;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         stg_wr       <= '0;
         stg_rd       <= '0;
         stg_cnt      <= '0;
         if_wr        <= '0;
         if_rd        <= '0;
         if_cnt       <= '0;
         for (int c = 0; c < int'(NUM_CLASS); c++) begin
            evt_wr[c]  <= '0;
            evt_rd[c]  <= '0;
            evt_cnt[c] <= '0;
         end
         wrr_ptr      <= '0;
         wrr_credit   <= '0;
         deq_req      <= 1'b0;
         deq_qid      <= '0;
         deq_class    <= '0;
         evt_overflow <= '0;
         inflight_err <= 1'b0;
      end else begin
         if (stg_push) stg_wr <= stg_wr + 2'd1;
         if (stg_pop)  stg_rd <= stg_rd + 2'd1;
         stg_cnt <= stg_cnt + 3'(stg_push) - 3'(stg_pop);
         if (sel_vld) if_wr <= if_inc(if_wr);
         if (if_pop)  if_rd <= if_inc(if_rd);
         if_cnt <= if_cnt + IF_CW'(sel_vld) - IF_CW'(if_pop);
         for (int c = 0; c < int'(NUM_CLASS); c++) begin
            if (evt_wr_en[c]) evt_wr[c] <= evt_wr[c] + EVT_DEPTH_NBITS'(1);
            if (evt_pop[c])   evt_rd[c] <= evt_rd[c] + EVT_DEPTH_NBITS'(1);
            evt_cnt[c] <= evt_cnt[c] + EC'(evt_wr_en[c]) - EC'(evt_pop[c]);
         end
         wrr_ptr      <= ptr_nxt;
         wrr_credit   <= credit_nxt;
         evt_overflow <= evt_overflow | ovf_set;
         if (deq_depth_ack && (if_cnt == '0)) inflight_err <= 1'b1;
         deq_req <= sel_vld;
         if (sel_vld) begin
            deq_qid   <= sel_qid;
            deq_class <= sel_cls;
         end
      end
   end

   // Storage arrays carry no reset; occupancy is tracked by the counters above
   always_ff @(posedge clk) begin
      if (stg_push) stg_mem[stg_wr] <= {enq_ack_qid, enq_ack_class};
      if (sel_vld)  if_mem[if_wr]   <= {sel_qid, sel_cls};
      for (int c = 0; c < int'(NUM_CLASS); c++)
         if (evt_wr_en[c]) evt_mem[c][evt_wr[c]] <= push_qid;
   end
endmodule

// File: tb/tb_piarb_class_sch.sv
// Scoreboard bench for piarb_class_sch: expected grants are queued with stimulus
// and popped as deq_req pulses appear.
module tb_piarb_class_sch;
   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic        enq_ack = 1'b0, enq_to_empty = 1'b0;
   logic [4:0]  enq_ack_qid = '0;
   logic [1:0]  enq_ack_class = '0;
   logic        deq_depth_ack = 1'b0, deq_depth_from_emptyp2 = 1'b0;
   logic        mode = 1'b0;
   logic [15:0] weight = '0;
   logic        deq_ready = 1'b0;
   logic        deq_req;
   logic [4:0]  deq_qid;
   logic [1:0]  deq_class;
   logic [3:0]  evt_overflow;
   logic        inflight_err;

   int          checks = 0;
   int          failures = 0;
   int          grants = 0;
   int          g0;
   int          n;
   logic [6:0]  exp_q [$];
   logic [6:0]  mon_e;
   logic        auto_ack = 1'b0;
   logic [31:0] rearm_pend = '0;
   int          wrr_qid [10] = '{0, 16, 17, 18, 1, 19, 16, 17, 2, 3};
   int          wrr_cls [10] = '{0, 1, 1, 1, 0, 1, 1, 1, 0, 0};

   always #5 clk = ~clk;

   piarb_class_sch dut (
      .clk(clk), .rstn(rstn),
      .enq_ack(enq_ack), .enq_to_empty(enq_to_empty),
      .enq_ack_qid(enq_ack_qid), .enq_ack_class(enq_ack_class),
      .deq_depth_ack(deq_depth_ack), .deq_depth_from_emptyp2(deq_depth_from_emptyp2),
      .mode(mode), .weight(weight), .deq_ready(deq_ready),
      .deq_req(deq_req), .deq_qid(deq_qid), .deq_class(deq_class),
      .evt_overflow(evt_overflow), .inflight_err(inflight_err)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Grant monitor / scoreboard
   always @(negedge clk) begin
      if (rstn && deq_req) begin
         grants++;
         if (exp_q.size() == 0) begin
            check("deq_unexpected", 32'(deq_req), 32'd0);
         end else begin
            mon_e = exp_q.pop_front();
            check("deq_qid", 32'(deq_qid), 32'(mon_e[4:0]));
            check("deq_class", 32'(deq_class), 32'(mon_e[6:5]));
         end
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
      enq_ack = 1'b0;
      enq_to_empty = 1'b0;
      deq_depth_ack = 1'b0;
      deq_depth_from_emptyp2 = 1'b0;
      if (auto_ack && deq_req) begin
         deq_depth_ack = 1'b1;
         deq_depth_from_emptyp2 = rearm_pend[deq_qid];
         rearm_pend[deq_qid] = 1'b0;
      end
   endtask

   task automatic enq(input int q, input int c, input logic to_empty);
      cyc();
      enq_ack = 1'b1;
      enq_to_empty = to_empty;
      enq_ack_qid = 5'(q);
      enq_ack_class = 2'(c);
   endtask

   task automatic expect_deq(input int q, input int c);
      exp_q.push_back({2'(c), 5'(q)});
   endtask

   task automatic drain(input int max, input string tag);
      int k;
      k = 0;
      while (exp_q.size() != 0 && k < max) begin
         cyc();
         k++;
      end
      check(tag, 32'(exp_q.size()), 32'd0);
      cyc();
      cyc();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      #2;
      check("rst_deq_req", 32'(deq_req), 32'd0);
      check("rst_deq_qid", 32'(deq_qid), 32'd0);
      check("rst_deq_class", 32'(deq_class), 32'd0);
      check("rst_overflow", 32'(evt_overflow), 32'd0);
      check("rst_inflight_err", 32'(inflight_err), 32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rstn = 1'b1;

      // Strict priority
      mode = 1'b0; deq_ready = 1'b0; auto_ack = 1'b1;
      enq(3, 2, 1'b1); enq(7, 0, 1'b1); enq(30, 3, 1'b0);
      expect_deq(7, 0); expect_deq(3, 2);
      repeat (4) cyc();
      deq_ready = 1'b1;
      drain(20, "strict1_drain");
      deq_ready = 1'b0;
      enq(20, 3, 1'b1); enq(21, 1, 1'b1); enq(22, 2, 1'b1); enq(23, 1, 1'b1); enq(24, 0, 1'b1);
      expect_deq(24, 0); expect_deq(21, 1); expect_deq(23, 1); expect_deq(22, 2); expect_deq(20, 3);
      repeat (4) cyc();
      deq_ready = 1'b1;
      drain(20, "strict2_drain");

      // Re-arm takes precedence over a same-cycle enqueue event
      auto_ack = 1'b0; deq_ready = 1'b1;
      enq(9, 1, 1'b1);
      expect_deq(9, 1);
      n = 0;
      do begin cyc(); n++; end while (!deq_req && n < 20);
      check("rearm_setup_req", 32'(deq_req), 32'd1);
      deq_ready = 1'b0;
      cyc();
      enq_ack = 1'b1; enq_to_empty = 1'b1; enq_ack_qid = 5'd5; enq_ack_class = 2'd1;
      deq_depth_ack = 1'b1; deq_depth_from_emptyp2 = 1'b1;
      expect_deq(9, 1); expect_deq(5, 1);
      repeat (4) cyc();
      deq_ready = 1'b1; auto_ack = 1'b1;
      drain(20, "rearm_drain");

      // In-flight limit
      auto_ack = 1'b0; deq_ready = 1'b0;
      for (int i = 0; i < 6; i++) begin
         enq(10 + i, 0, 1'b1);
         expect_deq(10 + i, 0);
      end
      repeat (4) cyc();
      g0 = grants;
      deq_ready = 1'b1;
      repeat (12) cyc();
      check("inflight_cap", 32'(grants - g0), 32'd4);
      cyc();
      deq_depth_ack = 1'b1;
      check("no_req_in_ack_cycle", 32'(deq_req), 32'd0);
      cyc();
      check("req_after_ack", 32'(deq_req), 32'd1);
      repeat (5) begin cyc(); deq_depth_ack = 1'b1; end
      drain(20, "inflight_drain");
      check("no_inflight_err_yet", 32'(inflight_err), 32'd0);

      // Weighted round-robin, weights class0=1 class1=3
      mode = 1'b1; weight = 16'h0031; deq_ready = 1'b0; auto_ack = 1'b1;
      rearm_pend = '0; rearm_pend[16] = 1'b1; rearm_pend[17] = 1'b1;
      for (int i = 0; i < 4; i++) enq(i, 0, 1'b1);
      for (int i = 0; i < 4; i++) enq(16 + i, 1, 1'b1);
      for (int i = 0; i < 10; i++) expect_deq(wrr_qid[i], wrr_cls[i]);
      repeat (4) cyc();
      deq_ready = 1'b1;
      drain(40, "wrr_drain");

      // Class event FIFO overflow
      mode = 1'b0; deq_ready = 1'b0;
      for (int i = 0; i < 32; i++) begin
         enq(i, 1, 1'b1);
         expect_deq(i, 1);
      end
      repeat (3) cyc();
      check("ovf_before", 32'(evt_overflow), 32'd0);
      enq(31, 1, 1'b1);
      repeat (3) cyc();
      check("ovf_set", 32'(evt_overflow), 32'h2);
      deq_ready = 1'b1;
      drain(100, "ovf_drain");
      check("ovf_sticky", 32'(evt_overflow), 32'h2);

      // Ack with nothing outstanding
      g0 = grants;
      cyc();
      deq_depth_ack = 1'b1; deq_depth_from_emptyp2 = 1'b1;
      cyc();
      check("inflight_err", 32'(inflight_err), 32'd1);
      repeat (6) cyc();
      check("no_evt_from_err", 32'(grants - g0), 32'd0);

      // Reset in the middle of pending work
      deq_ready = 1'b0;
      enq(1, 0, 1'b1); enq(2, 3, 1'b1);
      cyc();
      #3 rstn = 1'b0;
      #1;
      check("mrst_deq_req", 32'(deq_req), 32'd0);
      check("mrst_deq_qid", 32'(deq_qid), 32'd0);
      check("mrst_deq_class", 32'(deq_class), 32'd0);
      check("mrst_overflow", 32'(evt_overflow), 32'd0);
      check("mrst_inflight_err", 32'(inflight_err), 32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rstn = 1'b1;
      g0 = grants;
      deq_ready = 1'b1;
      cyc();
      check("mrst_first_cycle", 32'(deq_req), 32'd0);
      repeat (8) cyc();
      check("mrst_discard", 32'(grants - g0), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
